// File: rtl/sized_bus_interface_pkg.sv
// Shared state codes, size encodings and mask helpers for the sized bus master.
package bus_interface_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;

    typedef enum logic [1:0] {
        SIZE_1 = 2'd0,
        SIZE_2 = 2'd1,
        SIZE_4 = 2'd2,
        SIZE_8 = 2'd3
    } size_e;

    function automatic logic [3:0] beat_count(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // Low address bits that must be zero for a transfer of this size.
    function automatic logic [31:0] align_mask(input logic [1:0] size, input int unsigned byte_shift);
        return (32'd1 << (byte_shift + 32'(size))) - 32'd1;
    endfunction

endpackage

// File: rtl/sized_bus_interface_if.sv
// External narrow-bus signal bundle; the master drives address/data/strobes.
interface sized_bus_interface_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int BUS_WIDTH     = 8
);
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic [BUS_WIDTH-1:0]     bus_data_out;
    logic                     bus_enable;
    logic                     bus_mio;
    logic                     bus_read;
    logic [BUS_WIDTH-1:0]     bus_data_in;
    logic                     bus_wait;

    modport master (
        output bus_address, bus_data_out, bus_enable, bus_mio, bus_read,
        input  bus_data_in, bus_wait
    );

    modport slave (
        input  bus_address, bus_data_out, bus_enable, bus_mio, bus_read,
        output bus_data_in, bus_wait
    );
endinterface

// File: rtl/sized_bus_interface_wait_timer.sv
// Wait-state down-counter and consecutive-stall counter for one bus beat.
module bus_wait_timer #(
    parameter int WAIT_WIDTH = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_WIDTH-1:0] load_value,
    input  logic                  count,
    input  logic                  stall,
    output logic                  zero,
    output logic                  expired
);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [WAIT_WIDTH-1:0] wait_count_reg;
    logic [STALL_W-1:0]    stall_count_reg;

    assign zero    = (wait_count_reg == '0);
    // High during the stall cycle that would be the TIMEOUT-th in a row.
    assign expired = (stall_count_reg == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_count_reg <= '0;
        end else if (load) begin
            wait_count_reg <= load_value;
        end else if (count && !zero) begin
            wait_count_reg <= wait_count_reg - WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || load) begin
            stall_count_reg <= '0;
        end else if (stall) begin
            stall_count_reg <= expired ? '0 : stall_count_reg + STALL_W'(1);
        end
    end

endmodule

// File: rtl/sized_bus_interface.sv
// Multi-beat bus master: moves one 1/2/4/8-beat CPU transaction over a narrow bus.
module sized_bus_interface
    import bus_interface_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BUS_WIDTH     = 8,
    parameter int WAIT_WIDTH    = 3,
    parameter int TIMEOUT       = 15,
    parameter int ALIGN_CHECK   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     is_write,
    input  logic                     is_memory,
    input  logic [1:0]               size,
    input  logic                     sign_extend,
    input  logic [WAIT_WIDTH-1:0]    wait_states,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    read_data,
    sized_bus_interface_if.master    bus
);
    localparam int BEATS      = DATA_WIDTH / BUS_WIDTH;
    localparam int BUS_BYTES  = BUS_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BUS_BYTES);
    localparam int BEAT_W     = $clog2(BEATS);

    logic [1:0]               state_reg;
    logic [BEAT_W-1:0]        beat_reg;
    logic [ADDRESS_WIDTH-1:0] bus_address_reg;
    logic [DATA_WIDTH-1:0]    write_data_reg;
    logic [DATA_WIDTH-1:0]    read_data_reg;
    size_e                    size_reg;
    logic                     sign_extend_reg;
    logic [WAIT_WIDTH-1:0]    wait_reg;
    logic                     done_reg;
    logic                     error_reg;
    logic                     bus_enable_reg;
    logic                     bus_mio_reg;
    logic                     bus_read_reg;

    logic size_bad;
    logic misaligned;
    logic accept;
    logic reject;
    logic strobe_active;
    logic commit;
    logic stall;
    logic last_beat;
    logic wait_zero;
    logic stall_expired;
    logic timer_load;
    logic fill_bit;
    logic [WAIT_WIDTH-1:0] timer_load_value;
    logic [DATA_WIDTH-1:0] read_data_merged;
    logic [DATA_WIDTH-1:0] read_data_final;

    assign size_bad   = beat_count(size) > 4'(BEATS);
    assign misaligned = (ALIGN_CHECK != 0) &&
                        ((address & ADDRESS_WIDTH'(align_mask(size, BYTE_SHIFT))) != '0);
    assign accept     = (state_reg == IDLE) && start && !size_bad && !misaligned;
    assign reject     = (state_reg == IDLE) && start && (size_bad || misaligned);

    // A zero wait counter in COUNT strobes in the same cycle, so W=0 gives one beat per cycle.
    assign strobe_active = (state_reg == STROBE) || ((state_reg == COUNT) && wait_zero);
    assign commit        = strobe_active && !bus.bus_wait;
    assign stall         = strobe_active && bus.bus_wait;
    assign last_beat     = (4'(beat_reg) == beat_count(size_reg) - 4'd1);

    assign timer_load       = accept || (commit && !last_beat);
    assign timer_load_value = (state_reg == IDLE) ? wait_states : wait_reg;

    bus_wait_timer #(
        .WAIT_WIDTH (WAIT_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .count      (state_reg == COUNT),
        .stall      (stall),
        .zero       (wait_zero),
        .expired    (stall_expired)
    );

    assign fill_bit = sign_extend_reg & bus.bus_data_in[BUS_WIDTH-1];

    // Per-beat slot: merge the incoming beat, then extend above the transfer size.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            assign read_data_merged[gi*BUS_WIDTH +: BUS_WIDTH] =
                (BEAT_W'(gi) == beat_reg) ? bus.bus_data_in
                                          : read_data_reg[gi*BUS_WIDTH +: BUS_WIDTH];
            assign read_data_final[gi*BUS_WIDTH +: BUS_WIDTH] =
                (4'(gi) < beat_count(size_reg)) ? read_data_merged[gi*BUS_WIDTH +: BUS_WIDTH]
                                                : {BUS_WIDTH{fill_bit}};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            beat_reg        <= '0;
            bus_address_reg <= '0;
            write_data_reg  <= '0;
            read_data_reg   <= '0;
            size_reg        <= SIZE_1;
            sign_extend_reg <= 1'b0;
            wait_reg        <= '0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            bus_enable_reg  <= 1'b0;
            bus_mio_reg     <= 1'b0;
            bus_read_reg    <= 1'b1;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (reject) begin
                        done_reg  <= 1'b1;
                        error_reg <= 1'b1;
                    end else if (accept) begin
                        bus_address_reg <= address;
                        write_data_reg  <= write_data;
                        bus_read_reg    <= ~is_write;
                        bus_mio_reg     <= is_memory;
                        size_reg        <= size_e'(size);
                        sign_extend_reg <= sign_extend;
                        wait_reg        <= wait_states;
                        read_data_reg   <= '0;
                        beat_reg        <= '0;
                        bus_enable_reg  <= 1'b1;
                        state_reg       <= COUNT;
                    end
                end
                COUNT, STROBE: begin
                    if (stall) begin
                        if (stall_expired) begin
                            state_reg      <= IDLE;
                            bus_enable_reg <= 1'b0;
                            done_reg       <= 1'b1;
                            error_reg      <= 1'b1;
                        end else begin
                            state_reg <= STROBE;
                        end
                    end else if (commit) begin
                        if (bus_read_reg) begin
                            read_data_reg <= last_beat ? read_data_final : read_data_merged;
                        end
                        if (last_beat) begin
                            state_reg      <= IDLE;
                            bus_enable_reg <= 1'b0;
                            done_reg       <= 1'b1;
                        end else begin
                            beat_reg        <= beat_reg + BEAT_W'(1);
                            bus_address_reg <= bus_address_reg + ADDRESS_WIDTH'(BUS_BYTES);
                            state_reg       <= COUNT;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy             = (state_reg != IDLE);
    assign done             = done_reg;
    assign error            = error_reg;
    assign read_data        = read_data_reg;
    assign bus.bus_address  = bus_address_reg;
    assign bus.bus_data_out = write_data_reg[beat_reg*BUS_WIDTH +: BUS_WIDTH];
    assign bus.bus_enable   = bus_enable_reg;
    assign bus.bus_mio      = bus_mio_reg;
    assign bus.bus_read     = bus_read_reg;

endmodule
